gb_apu_i2s_tx: RTL and testbench
================================

// Module: gb_apu_i2s_tx
// PURPOSE
//  Consumes the APU's 16-bit left/right mix and serializes it as a standard Philips I2S stream
//   (BCLK, LRCLK, SDATA) for an external DAC.
//  Sits downstream of gb_APU; a 2-word holding register decouples APU sample production from frame timing.
//  The DAC is the I2S receiver; this block is the transmitter and the sole clock master.
// PARAMETERS
//  WIDTH     16  bits per channel slot; frame = 2*WIDTH BCLK periods
//  BCLK_DIV  4   clk cycles per BCLK half-period (>=1); BCLK period = 2*BCLK_DIV clk
// PORTS
//  clk             in   1      system clock, single domain
//  reset           in   1      synchronous, active-high
//  left_i          in   WIDTH  left sample, two's complement
//  right_i         in   WIDTH  right sample, two's complement
//  sample_valid_i  in   1      left_i/right_i valid this cycle
//  sample_ready_o  out  1      holding register empty; transfer = valid & ready
//  bclk_o          out  1      bit clock; data changes on falling edge, DAC samples on rising edge
//  lrclk_o         out  1      0 = left slot, 1 = right slot
//  sdata_o         out  1      serial data, MSB first, one BCLK after the LRCLK edge
//  underrun_o      out  1      one-clk pulse: frame started with holding register empty
// BEHAVIOUR
//  Reset values: bclk_o=0, lrclk_o=0, sdata_o=0, underrun_o=0, sample_ready_o=1.
//   Reset clears div_cnt, bit_cnt, holding register and shift register (last_frame={0,0}). Reset wins over all events.
//  Divider: div_cnt counts 0..BCLK_DIV-1 and toggles bclk_o at terminal count.
//   fall_stb is asserted in the clk cycle in which bclk_o goes 1->0.
//  bit_cnt (0..2*WIDTH-1) advances by 1 mod 2*WIDTH on each fall_stb.
//   The first fall_stb after reset presents n=0.
//  On fall_stb with new bit_cnt n, outputs register in the same edge:
//   lrclk_o = (n >= WIDTH)
//   sdata_o = bit (2*WIDTH-n) of frame {L,R}; n=0 emits the R LSB of the previous frame (I2S 1-bit delay).
//   Implement as a 2*WIDTH+1-bit shift register.
//  Frame load occurs at fall_stb with n=0:
//   Holding full: the frame takes the holding contents; holding is cleared, so ready=1 next cycle.
//   Holding empty with a same-cycle transfer: bypass; the frame takes left_i/right_i directly,
//    holding stays empty, no underrun.
//   Holding empty with no transfer: the frame repeats last_frame and underrun_o pulses for 1 clk.
//  Transfer while ready and not at a load: left_i/right_i are captured into holding; ready=0 from the next cycle.
//  sample_ready_o is registered; it depends only on holding occupancy (no combinational path from valid).
//  Samples are never dropped; producer backpressure is via ready only.
//  Output sample rate = clk / (4*WIDTH*BCLK_DIV); at 4.194304 MHz, W=16, DIV=2: 32768 Hz.
//  Reset mid-frame: all outputs return to reset values next cycle; the frame restarts at n=0 with zeros.
// STRUCTURE
//  gb_apu_pkg: localparams I2S_WIDTH=16 and I2S_BCLK_DIV; typedef struct packed {logic [15:0] l, r;} stereo_sample_t.
//  Sub-module gb_i2s_clkgen: div_cnt, bclk_o, fall_stb, bit_cnt, frame_start.
//   The top level owns the holding register, shift register, lrclk/sdata and underrun.
// TESTING
//  1 Reset then idle: bclk period 2*BCLK_DIV clk; first n=0 after 2*BCLK_DIV clk -> underrun pulse,
//    sdata_o all 0 for frame 0.
//  2 W=16, DIV=2: L=16'hA5F0, R=16'h0F0F pushed before frame 0 -> sampled on rising BCLK:
//    lrclk 0 x16 then 1 x16; bits 1..16 = A5F0 MSB first; bits 17..31 = 0F0F[15:1];
//    next frame bit 0 = 1 (R LSB).
//  3 Backpressure: hold valid=1 with incrementing L/R -> ready drops after each accept;
//    exactly one sample per 128-clk frame; no gaps or repeats over 8 frames; no underrun.
//  4 Bypass: assert valid only in the fall_stb n=0 cycle with L=16'h8001, R=16'h7FFE, holding empty
//    -> frame carries 8001/7FFE; underrun_o stays 0.
//  5 Underrun: load one sample (L=16'h1234, R=16'h5678), then stop -> next frame repeats 1234/5678;
//    underrun_o pulses once per starved frame.
//  6 Reset at bit_cnt=20 mid-frame -> next cycle bclk/lrclk/sdata=0, ready=1;
//    the following frame starts at n=0 with correct timing.

Source files
------------

// File: rtl/gb_apu_pkg.sv
// rtl/gb_apu_pkg.sv - shared constants and types for the APU audio output path
// Purpose: default I2S slot width and bit-clock divider, plus the stereo sample record.
// Ports: none (package).
package gb_apu_pkg;

  localparam int I2S_WIDTH    = 16;
  localparam int I2S_BCLK_DIV = 4;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/gb_i2s_clkgen.sv
// rtl/gb_i2s_clkgen.sv - I2S bit clock divider and frame bit counter
// Purpose: divides clk into BCLK, flags the BCLK falling edge and tracks the slot bit index.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   bclk_o         bit clock (0 after reset)
//   fall_stb_o     high in the clk cycle whose closing edge takes bclk_o 1->0
//   bit_cnt_o      bit index n presented at the current fall_stb_o
//   frame_start_o  fall_stb_o with n = 0 (frame load point)
module gb_i2s_clkgen
  import gb_apu_pkg::*;
#(
  parameter int WIDTH    = I2S_WIDTH,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         bclk_o,
  output logic                         fall_stb_o,
  output logic [$clog2(2*WIDTH)-1:0]   bit_cnt_o,
  output logic                         frame_start_o
);

  localparam int DIVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW   = $clog2(2*WIDTH);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(2*WIDTH - 1);

  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  // bit_cnt_q holds the index that the next fall_stb presents, so it
  // starts at 0 after reset and the first falling edge presents n = 0.
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            div_tc;
  logic            fall_stb;

  always_comb begin
    div_tc    = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
    bclk_d    = bclk_q ^ div_tc;
    fall_stb  = div_tc & bclk_q;
    bit_cnt_d = bit_cnt_q;
    if (fall_stb) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bclk_o        = bclk_q;
  assign fall_stb_o    = fall_stb;
  assign bit_cnt_o     = bit_cnt_q;
  assign frame_start_o = fall_stb & (bit_cnt_q == '0);

endmodule

// File: rtl/gb_apu_i2s_tx.sv
// rtl/gb_apu_i2s_tx.sv - Philips I2S transmitter for the APU stereo mix
// Purpose: buffers one L/R sample and serializes frames as I2S master (BCLK, LRCLK, SDATA).
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   left_i, right_i       two's complement samples, WIDTH bits each
//   sample_valid_i        sample present; accepted when sample_ready_o is high
//   sample_ready_o        holding register empty (registered)
//   bclk_o, lrclk_o       bit clock and word select (0 = left slot)
//   sdata_o               serial data, MSB first, one BCLK after the LRCLK edge
//   underrun_o            one-clk pulse when a frame starts with no sample available
module gb_apu_i2s_tx
  import gb_apu_pkg::*;
#(
  parameter int WIDTH    = I2S_WIDTH,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  output logic             bclk_o,
  output logic             lrclk_o,
  output logic             sdata_o,
  output logic             underrun_o
);

  localparam int FW = 2*WIDTH;
  localparam int BW = $clog2(FW);

  logic          fall_stb;
  logic          frame_start;
  logic [BW-1:0] bit_cnt;

  gb_i2s_clkgen #(
    .WIDTH    (WIDTH),
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk           (clk),
    .reset         (reset),
    .bclk_o        (bclk_o),
    .fall_stb_o    (fall_stb),
    .bit_cnt_o     (bit_cnt),
    .frame_start_o (frame_start)
  );

  logic [FW-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [FW-1:0] last_frame_q, last_frame_d;
  // Bit FW is the line bit; bit FW-1 carries the previous frame's R LSB
  // into the next load, giving the one-BCLK I2S delay.
  logic [FW:0]   sr_q, sr_d;
  logic          lrclk_q, lrclk_d;
  logic          underrun_q, underrun_d;
  logic          xfer;
  logic [FW-1:0] frame_sel;

  always_comb begin
    xfer         = sample_valid_i & ~hold_full_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_frame_d = last_frame_q;
    sr_d         = sr_q;
    lrclk_d      = lrclk_q;
    underrun_d   = 1'b0;
    frame_sel    = last_frame_q;

    if (frame_start) begin
      if (hold_full_q) begin
        frame_sel   = hold_q;
        hold_full_d = 1'b0;
      end else if (xfer) begin
        // Bypass: a sample arriving exactly at the load goes straight to the frame.
        frame_sel = {left_i, right_i};
      end else begin
        underrun_d = 1'b1;
      end
      last_frame_d = frame_sel;
      sr_d         = {sr_q[FW-1], frame_sel};
    end else begin
      if (xfer) begin
        hold_d      = {left_i, right_i};
        hold_full_d = 1'b1;
      end
      if (fall_stb) begin
        sr_d = {sr_q[FW-1:0], 1'b0};
      end
    end

    if (fall_stb) begin
      lrclk_d = (bit_cnt >= BW'(WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_frame_q <= '0;
      sr_q         <= '0;
      lrclk_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_frame_q <= last_frame_d;
      sr_q         <= sr_d;
      lrclk_q      <= lrclk_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sample_ready_o = ~hold_full_q;
  assign lrclk_o        = lrclk_q;
  assign sdata_o        = sr_q[FW];
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_gb_apu_i2s_tx.sv
// tb/tb_gb_apu_i2s_tx.sv - scoreboard bench for the APU I2S transmitter
module tb_gb_apu_i2s_tx;
  import gb_apu_pkg::*;

  localparam int W         = 16;
  localparam int DIV       = 2;
  localparam int FRAME_CLK = 4*W*DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  logic        valid = 1'b0;
  logic        ready, bclk, lrclk, sdata, underrun;

  gb_apu_i2s_tx #(.WIDTH(W), .BCLK_DIV(DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .left_i         (left),
    .right_i        (right),
    .sample_valid_i (valid),
    .sample_ready_o (ready),
    .bclk_o         (bclk),
    .lrclk_o        (lrclk),
    .sdata_o        (sdata),
    .underrun_o     (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] lr;
    logic        uf;
    int          start;
  } frame_t;

  typedef struct {
    stereo_sample_t s;
    int             acc;
  } push_t;

  frame_t      rx_q[$];
  push_t       exp_q[$];
  logic [31:0] last_exp = '0;
  int          mon_k = -1;
  int          ur_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          c_r = 0;

  // Receiver model: samples SDATA/LRCLK on rising BCLK, frames aligned by falling edges.
  initial begin
    frame_t cur, pend;
    bit     cur_v;
    logic   bp;
    cur_v = 0;
    bp    = 0;
    pend  = '{data: '0, lr: '0, uf: 1'b0, start: 0};
    cur   = pend;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_k  = -1;
        cur_v  = 0;
        bp     = 0;
        ur_cnt = 0;
      end else begin
        if (underrun) ur_cnt++;
        if (bp && !bclk) begin
          mon_k = (mon_k == 2*W-1) ? 0 : mon_k + 1;
          if (mon_k == 0) begin
            pend.data  = '0;
            pend.lr    = '0;
            pend.uf    = underrun;
            pend.start = cyc;
          end
        end else if (!bp && bclk && mon_k >= 0) begin
          if (mon_k == 0) begin
            if (cur_v) begin
              cur.data[0] = sdata;
              rx_q.push_back(cur);
            end
            cur   = pend;
            cur_v = 1;
          end else begin
            cur.data[2*W-mon_k] = sdata;
          end
          cur.lr[2*W-1-mon_k] = lrclk;
        end
        bp = bclk;
      end
    end
  end

  // Expected frame for a load at edge 'start': oldest sample accepted by then, else repeat.
  task automatic model_next(input int start, output logic [31:0] d, output logic uf);
    push_t p;
    if (exp_q.size() > 0 && exp_q[0].acc <= start) begin
      p  = exp_q.pop_front();
      d  = {p.s.l, p.s.r};
      uf = 1'b0;
    end else begin
      d  = last_exp;
      uf = 1'b1;
    end
    last_exp = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rx_q.delete();
    exp_q.delete();
    last_exp = '0;
    reset    = 1'b0;
    c_r      = cyc;
  endtask

  // Called just after a posedge; holds valid until accepted, then drops it.
  task automatic push_sample(input logic [15:0] l, input logic [15:0] r,
                             output int acc, output bit ok);
    push_t p;
    ok    = 0;
    acc   = -1;
    valid = 1'b1;
    left  = l;
    right = r;
    for (int t = 0; t < 2000; t++) begin
      if (ready) begin
        acc   = cyc + 1;
        p.s.l = l;
        p.s.r = r;
        p.acc = acc;
        exp_q.push_back(p);
        ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 0;
    for (int t = 0; t < n*FRAME_CLK + 400; t++) begin
      if (rx_q.size() >= n) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    frame_t f;
    logic [31:0] ed;
    logic eu;
    bit ok;
    do_reset();
    checks++;
    if ({bclk, lrclk, sdata, underrun, ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_values got %b exp 00001", {bclk, lrclk, sdata, underrun, ready});
    end
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      checks++;
      if ({bclk, underrun, lrclk, sdata} !== {1'((j >> 1) & 1), (j == 4), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_timing edge %0d got bclk/ur/lr/sd %b exp %b", j,
                 {bclk, underrun, lrclk, sdata}, {1'((j >> 1) & 1), (j == 4), 1'b0, 1'b0});
      end
    end
    wait_frames(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_frame_timeout got 0 frames exp 1");
    end else begin
      f = rx_q.pop_front();
      model_next(f.start, ed, eu);
      checks += 4;
      if (f.start !== c_r + 2*DIV) begin
        errors++; $display("FAIL reset_first_load got %0d exp %0d", f.start - c_r, 2*DIV);
      end
      if (f.data !== ed) begin
        errors++; $display("FAIL reset_frame0_data got %h exp %h", f.data, ed);
      end
      if (f.uf !== eu) begin
        errors++; $display("FAIL reset_frame0_underrun got %b exp %b", f.uf, eu);
      end
      if (f.lr !== 32'h0000FFFF) begin
        errors++; $display("FAIL reset_frame0_lrclk got %h exp 0000ffff", f.lr);
      end
    end
  endtask

  task automatic test_pattern();
    frame_t f;
    logic [31:0] ed;
    logic eu;
    bit ok;
    int acc;
    do_reset();
    push_sample(16'hA5F0, 16'h0F0F, acc, ok);
    wait_frames(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL pattern_timeout got %0d frames exp 2", rx_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        f = rx_q.pop_front();
        model_next(f.start, ed, eu);
        checks += 3;
        if (f.data !== ed) begin
          errors++; $display("FAIL pattern_data frame %0d got %h exp %h", i, f.data, ed);
        end
        if (f.uf !== eu) begin
          errors++; $display("FAIL pattern_underrun frame %0d got %b exp %b", i, f.uf, eu);
        end
        if (f.lr !== 32'h0000FFFF) begin
          errors++; $display("FAIL pattern_lrclk frame %0d got %h exp 0000ffff", i, f.lr);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    frame_t f;
    logic [31:0] ed;
    logic eu;
    bit ok;
    int acc[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_sample(16'h1000 + 16'(i), 16'h2000 + 16'(i), acc[i], ok);
      checks += 2;
      if (!ok) begin
        errors++; $display("FAIL bp_accept sample %0d got none exp accept", i);
      end
      if (ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready_drop sample %0d got %b exp 0", i, ready);
      end
      if (i >= 2) begin
        checks++;
        if (acc[i] - acc[i-1] !== FRAME_CLK) begin
          errors++; $display("FAIL bp_spacing sample %0d got %0d exp %0d", i, acc[i] - acc[i-1], FRAME_CLK);
        end
      end
    end
    wait_frames(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_timeout got %0d frames exp 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        f = rx_q.pop_front();
        model_next(f.start, ed, eu);
        checks += 2;
        if (f.data !== ed) begin
          errors++; $display("FAIL bp_data frame %0d got %h exp %h", i, f.data, ed);
        end
        if (f.uf !== eu) begin
          errors++; $display("FAIL bp_underrun frame %0d got %b exp %b", i, f.uf, eu);
        end
      end
    end
  endtask

  task automatic test_bypass();
    frame_t f;
    logic [31:0] ed;
    logic eu;
    bit ok;
    push_t p;
    do_reset();
    repeat (2*DIV - 1) begin
      @(posedge clk); #1;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL bypass_ready_pre got %b exp 1", ready);
    end
    valid = 1'b1;
    left  = 16'h8001;
    right = 16'h7FFE;
    p.s.l = 16'h8001;
    p.s.r = 16'h7FFE;
    p.acc = cyc + 1;
    exp_q.push_back(p);
    @(posedge clk); #1;
    valid = 1'b0;
    checks += 2;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL bypass_ready_post got %b exp 1", ready);
    end
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL bypass_underrun got %b exp 0", underrun);
    end
    wait_frames(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bypass_timeout got %0d frames exp 2", rx_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        f = rx_q.pop_front();
        model_next(f.start, ed, eu);
        checks += 2;
        if (f.data !== ed) begin
          errors++; $display("FAIL bypass_data frame %0d got %h exp %h", i, f.data, ed);
        end
        if (f.uf !== eu) begin
          errors++; $display("FAIL bypass_uf frame %0d got %b exp %b", i, f.uf, eu);
        end
      end
    end
  endtask

  task automatic test_underrun();
    frame_t f;
    logic [31:0] ed;
    logic eu;
    bit ok;
    int acc;
    do_reset();
    push_sample(16'h1234, 16'h5678, acc, ok);
    wait_frames(3, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ur_timeout got %0d frames exp 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        f = rx_q.pop_front();
        model_next(f.start, ed, eu);
        checks += 2;
        if (f.data !== ed) begin
          errors++; $display("FAIL ur_data frame %0d got %h exp %h", i, f.data, ed);
        end
        if (f.uf !== eu) begin
          errors++; $display("FAIL ur_flag frame %0d got %b exp %b", i, f.uf, eu);
        end
      end
      checks++;
      if (ur_cnt !== 3) begin
        errors++; $display("FAIL ur_pulse_count got %0d exp 3", ur_cnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    frame_t f;
    logic [31:0] ed;
    logic eu;
    bit ok, found;
    int acc;
    do_reset();
    push_sample(16'hCAFE, 16'hBEEF, acc, ok);
    push_sample(16'hDEAD, 16'h0001, acc, ok);
    found = 0;
    for (int t = 0; t < 4*FRAME_CLK; t++) begin
      @(negedge clk);
      if (mon_k == 20) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midrst_reach_bit20 got %0d exp 20", mon_k);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bclk, lrclk, sdata, underrun, ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_outputs got %b exp 00001", {bclk, lrclk, sdata, underrun, ready});
    end
    @(posedge clk); #1;
    rx_q.delete();
    exp_q.delete();
    last_exp = '0;
    reset    = 1'b0;
    c_r      = cyc;
    wait_frames(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_timeout got 0 frames exp 1");
    end else begin
      f = rx_q.pop_front();
      model_next(f.start, ed, eu);
      checks += 3;
      if (f.start !== c_r + 2*DIV) begin
        errors++; $display("FAIL midrst_first_load got %0d exp %0d", f.start - c_r, 2*DIV);
      end
      if (f.data !== ed) begin
        errors++; $display("FAIL midrst_data got %h exp %h", f.data, ed);
      end
      if (f.uf !== eu) begin
        errors++; $display("FAIL midrst_uf got %b exp %b", f.uf, eu);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_backpressure();
    test_bypass();
    test_underrun();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
